// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator front end: operator codes,
// scanner state encodings, the physical key legend and operand width.
package calc_pkg;

  localparam int OPERAND_W = 36;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_EQ  = 3'd4,
    OP_CLR = 3'd5
  } op_code_t;

  // Scanner FSM encodings, kept as plain constants so older blocks can share them
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // One keypad position: either a decimal digit or an operator code
  typedef struct packed {
    logic       is_op;
    logic [3:0] value;
  } key_info_t;

  // Legend indexed by row*4+col:
  //   row0 = 1 2 3 ADD, row1 = 4 5 6 SUB, row2 = 7 8 9 MUL, row3 = CLR 0 EQ DIV
  localparam key_info_t KEY_MAP [16] = '{
    '{1'b0, 4'd1}, '{1'b0, 4'd2}, '{1'b0, 4'd3}, '{1'b1, {1'b0, OP_ADD}},
    '{1'b0, 4'd4}, '{1'b0, 4'd5}, '{1'b0, 4'd6}, '{1'b1, {1'b0, OP_SUB}},
    '{1'b0, 4'd7}, '{1'b0, 4'd8}, '{1'b0, 4'd9}, '{1'b1, {1'b0, OP_MUL}},
    '{1'b1, {1'b0, OP_CLR}}, '{1'b0, 4'd0}, '{1'b1, {1'b0, OP_EQ}}, '{1'b1, {1'b0, OP_DIV}}
  };

  function automatic key_info_t decode_key(input logic [3:0] code);
    return KEY_MAP[code];
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Row scanner for a 4x4 active-low keypad: column synchronizer, scan tick,
// press/release debounce FSM and one-hot row drive. Emits one key_valid
// pulse per debounced press with the key position in key_code.
module keypad_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 1,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int TICK_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE + 2);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SCAN_DIV);
  localparam logic [CNT_W-1:0]  DEB_TGT  = CNT_W'(DEBOUNCE);

  logic [3:0]        col_sync1;
  logic [3:0]        col_sync2;
  logic [1:0]        row_tag1;
  logic [1:0]        row_tag2;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [1:0]        state;
  logic [1:0]        row_idx;
  logic [1:0]        rec_col;
  logic [CNT_W-1:0]  stable_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              any_low;
  logic [1:0]        low_col;
  logic              sample_ok;

  assign row_n = ~(4'b0001 << row_idx);

  // Two-flop column synchronizer; the row tag travels alongside so each
  // synchronized sample is known to belong to the row that was driven
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_sync1 <= 4'b1111;
      col_sync2 <= 4'b1111;
      row_tag1  <= 2'd0;
      row_tag2  <= 2'd0;
    end else begin
      col_sync1 <= col_n;
      col_sync2 <= col_sync1;
      row_tag1  <= row_idx;
      row_tag2  <= row_tag1;
    end
  end

  // Free-running scan divider producing a one-clk tick at wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_MAX) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick      = (tick_cnt == TICK_MAX);
  assign any_low   = ~&col_sync2;
  // A sample taken while a previous row was still driven is stale; the scanner
  // waits on the current row until the synchronizer has caught up with it
  assign sample_ok = (row_tag2 == row_idx);
  assign cnt_inc   = stable_cnt + 1'b1;

  // Lowest-index low column wins when several keys in one row are down
  always_comb begin
    low_col = 2'd3;
    if (!col_sync2[0]) begin
      low_col = 2'd0;
    end else if (!col_sync2[1]) begin
      low_col = 2'd1;
    end else if (!col_sync2[2]) begin
      low_col = 2'd2;
    end
  end

  // Scan / debounce / hold / release-debounce state machine, advanced only on tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SCAN;
      row_idx    <= 2'd0;
      rec_col    <= 2'd0;
      stable_cnt <= '0;
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      key_valid <= 1'b0;
      if (tick && sample_ok) begin
        case (state)
          ST_SCAN: begin
            if (any_low) begin
              rec_col    <= low_col;
              stable_cnt <= CNT_W'(1);
              if (DEBOUNCE <= 1) begin
                state     <= ST_PRESSED;
                key_valid <= 1'b1;
                key_code  <= {row_idx, low_col};
              end else begin
                state <= ST_DEBOUNCE;
              end
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (!any_low) begin
              state <= ST_SCAN;
            end else if (low_col == rec_col) begin
              stable_cnt <= cnt_inc;
              if (cnt_inc >= DEB_TGT) begin
                state     <= ST_PRESSED;
                key_valid <= 1'b1;
                key_code  <= {row_idx, rec_col};
              end
            end else begin
              rec_col    <= low_col;
              stable_cnt <= CNT_W'(1);
            end
          end
          ST_PRESSED: begin
            if (!any_low) begin
              stable_cnt <= CNT_W'(1);
              state      <= (DEBOUNCE <= 1) ? ST_SCAN : ST_RELEASE;
            end
          end
          default: begin
            if (!any_low) begin
              stable_cnt <= cnt_inc;
              if (cnt_inc >= DEB_TGT) begin
                state <= ST_SCAN;
              end
            end else begin
              state <= ST_PRESSED;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry front end: scans the keypad, decodes accepted keys and builds
// a non-negative decimal operand, flagging operator and CLR keys on op_valid.
module keypad_entry
  import calc_pkg::*;
#(
  parameter int SCAN_DIV   = 1,
  parameter int DEBOUNCE   = 3,
  parameter int MAX_DIGITS = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  col_n,
  input  logic                        clear_entry,
  output logic [3:0]                  row_n,
  output logic                        key_valid,
  output logic [3:0]                  key_code,
  output logic                        op_valid,
  output logic [2:0]                  op_code,
  output logic signed [OPERAND_W-1:0] operand,
  output logic [3:0]                  digit_count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  key_info_t            key_info;
  logic [OPERAND_W-1:0] acc;
  logic [OPERAND_W-1:0] acc_next;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  assign key_info = decode_key(key_code);
  // Ten nines fit in 34 bits, so the unsigned 36-bit product never overflows
  assign acc_next = (acc * OPERAND_W'(10)) + {{(OPERAND_W-4){1'b0}}, key_info.value};
  assign operand  = signed'(acc);

  // Operator flagging and decimal accumulation; an operator clears the entry one
  // clk after op_valid so the consumer still sees the operand alongside the op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      digit_count <= 4'd0;
      op_valid    <= 1'b0;
      op_code     <= 3'd0;
    end else begin
      op_valid <= 1'b0;
      if (key_valid && key_info.is_op) begin
        op_valid <= 1'b1;
        op_code  <= key_info.value[2:0];
      end
      if (clear_entry || op_valid) begin
        acc         <= '0;
        digit_count <= 4'd0;
      end else if (key_valid && !key_info.is_op && (digit_count < MAX_CNT)) begin
        acc         <= acc_next;
        digit_count <= digit_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model drives col_n from the
// pressed-key set and row_n, stimulus pushes expected events computed from
// the keypad legend, and a monitor pops and checks each DUT event.
module tb_keypad_entry;

  localparam int CLKS_PER_TICK = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear_entry;
  logic [3:0]         col_n;
  logic [3:0]         row_n;
  logic               key_valid;
  logic [3:0]         key_code;
  logic               op_valid;
  logic [2:0]         op_code;
  logic signed [35:0] operand;
  logic [3:0]         digit_count;

  logic [15:0] keys_down;

  typedef struct {
    int     code;
    bit     is_op;
    int     op;
    longint entry_before;
    longint exp_operand;
    int     exp_count;
  } exp_t;

  exp_t   exp_q[$];
  longint m_operand;
  int     m_count;
  int     pass_count = 0;
  int     total_count = 0;

  // Printed legend of the keypad: digit value or -1, operator code or -1
  int key_digit [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};
  int key_op    [16] = '{-1, -1, -1, 0, -1, -1, -1, 1, -1, -1, -1, 2, 5, -1, 4, 3};

  keypad_entry #(
    .SCAN_DIV   (1),
    .DEBOUNCE   (3),
    .MAX_DIGITS (10)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .col_n       (col_n),
    .clear_entry (clear_entry),
    .row_n       (row_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .operand     (operand),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  // Physical keypad: a column reads low when a pressed key sits on a driven row
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys_down[r*4+c]) col_n[c] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tickWait(input int n);
    repeat (n * CLKS_PER_TICK) @(negedge clk);
  endtask

  // Reference model: record the expected event and advance the entry value
  task automatic modelPress(input int code, input bit clr);
    exp_t e;
    e.code = code;
    e.entry_before = m_operand;
    e.op = 0;
    if (key_digit[code] >= 0) begin
      e.is_op = 1'b0;
      if (clr) begin
        m_operand = 0;
        m_count = 0;
      end else if (m_count < 10) begin
        m_operand = m_operand * 10 + key_digit[code];
        m_count++;
      end
    end else begin
      e.is_op = 1'b1;
      e.op = key_op[code];
      m_operand = 0;
      m_count = 0;
    end
    e.exp_operand = m_operand;
    e.exp_count = m_count;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int code, input int hold_ticks, input int gap_ticks);
    modelPress(code, 1'b0);
    @(negedge clk);
    keys_down[code] = 1'b1;
    tickWait(hold_ticks);
    keys_down = '0;
    tickWait(gap_ticks);
  endtask

  task automatic pressBounce(input int code);
    modelPress(code, 1'b0);
    @(negedge clk);
    keys_down[code] = 1'b1;
    tickWait(1);
    keys_down[code] = 1'b0;
    tickWait(1);
    keys_down[code] = 1'b1;
    tickWait(1);
    keys_down[code] = 1'b0;
    tickWait(1);
    keys_down[code] = 1'b1;
    tickWait(24);
    keys_down = '0;
    tickWait(16);
  endtask

  task automatic pressWithClear(input int code);
    bit found;
    found = 1'b0;
    modelPress(code, 1'b1);
    @(negedge clk);
    keys_down[code] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (key_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("key_valid_timeout", key_valid, 1);
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    tickWait(12);
    keys_down = '0;
    tickWait(16);
  endtask

  task automatic clearBetween();
    @(negedge clk);
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    m_operand = 0;
    m_count = 0;
    @(negedge clk);
    checkOutput("clear_operand", operand, 0);
    checkOutput("clear_count", digit_count, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_row_n"}, row_n, 4'b1110);
    checkOutput({tag, "_key_valid"}, key_valid, 0);
    checkOutput({tag, "_op_valid"}, op_valid, 0);
    checkOutput({tag, "_key_code"}, key_code, 0);
    checkOutput({tag, "_op_code"}, op_code, 0);
    checkOutput({tag, "_operand"}, operand, 0);
    checkOutput({tag, "_digit_count"}, digit_count, 0);
  endtask

  // Monitor: every key_valid must match the oldest expectation, then the
  // operand / op outputs are checked on the following clks
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_key_valid", key_valid, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("key_code", key_code, e.code);
          @(negedge clk);
          if (!e.is_op) begin
            checkOutput("operand", operand, e.exp_operand);
            checkOutput("digit_count", digit_count, e.exp_count);
            checkOutput("no_op_on_digit", op_valid, 0);
          end else begin
            checkOutput("op_valid", op_valid, 1);
            checkOutput("op_code", op_code, e.op);
            checkOutput("operand_during_op", operand, e.entry_before);
            @(negedge clk);
            checkOutput("operand_after_op", operand, 0);
            checkOutput("count_after_op", digit_count, 0);
          end
        end
      end else if (op_valid) begin
        checkOutput("unexpected_op_valid", op_valid, 0);
      end
    end
  end

  initial begin : stimulus
    bit found;
    reset = 1'b1;
    clear_entry = 1'b0;
    keys_down = '0;
    m_operand = 0;
    m_count = 0;
    #1;
    checkResetValues("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tickWait(4);

    // 1,2,3 -> 123
    applyStimulus(0, 24, 16);
    applyStimulus(1, 24, 16);
    applyStimulus(2, 24, 16);
    // CLR, then 42 ADD
    applyStimulus(12, 24, 16);
    applyStimulus(4, 24, 16);
    applyStimulus(1, 24, 16);
    applyStimulus(3, 24, 16);
    // Bouncing key 5
    pressBounce(5);
    // EQ, then eleven nines saturating at ten digits, then DIV
    applyStimulus(14, 24, 16);
    repeat (11) applyStimulus(10, 24, 16);
    applyStimulus(15, 24, 16);
    // Keys 7 and 8 together, 8 released first
    modelPress(8, 1'b0);
    @(negedge clk);
    keys_down[8] = 1'b1;
    keys_down[9] = 1'b1;
    tickWait(24);
    keys_down[9] = 1'b0;
    tickWait(8);
    keys_down = '0;
    tickWait(16);
    // clear_entry coincident with digit 3: digit dropped
    pressWithClear(2);

    // Randomized key sequence with occasional clears
    repeat (20) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(20, 30)), int'($urandom_range(14, 20)));
      if ($urandom_range(0, 4) == 0) clearBetween();
    end

    // Reset during the debounce of key 6
    clearBetween();
    applyStimulus(10, 24, 16);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row_n == 4'b1110) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("row0_wait", row_n, 4'b1110);
    keys_down[6] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row_n == 4'b1101) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("row1_wait", row_n, 4'b1101);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    m_operand = 0;
    m_count = 0;
    #1;
    checkResetValues("midreset");
    repeat (3) @(negedge clk);
    modelPress(6, 1'b0);
    reset = 1'b0;
    tickWait(30);
    keys_down = '0;
    tickWait(16);

    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("final_operand", operand, m_operand);
    checkOutput("final_count", digit_count, m_count);
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 1: scan tick every SCAN_DIV+1 clk cycles.
REQ-002 Parameter DEBOUNCE, default 3: consecutive identical scan samples needed to accept a press or a release.
REQ-003 Parameter MAX_DIGITS, default 10: maximum accumulated decimal digits.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 col_n  in  4  keypad column sense, active-low, asynchronous to clk.
REQ-007 clear_entry  in  1  synchronous clear of accumulator and digit count.
REQ-008 row_n  out  4  row drive, one-hot active-low.
REQ-009 key_valid  out  1  one-clk pulse per accepted key press.
REQ-010 key_code  out  4  accepted key position, row*4+col, held until next accepted key.
REQ-011 op_valid  out  1  one-clk pulse when an operator or CLR key is accepted.
REQ-012 op_code  out  3  ADD=0, SUB=1, MUL=2, DIV=3, EQ=4, CLR=5; held until next op.
REQ-013 operand  out  signed 36  accumulated non-negative decimal entry.
REQ-014 digit_count  out  4  number of digits in operand, 0..MAX_DIGITS.

Function
REQ-015 Key map: row0 = 1,2,3,ADD; row1 = 4,5,6,SUB; row2 = 7,8,9,MUL; row3 = CLR,0,EQ,DIV.
REQ-016 col_n SHALL pass through a 2-flop synchronizer before any use; no other input is synchronized.
REQ-017 Scan tick: counter 0..SCAN_DIV, one-clk tick at wrap; all FSM sampling occurs only on tick.
REQ-018 FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-019 SCAN: on tick, any column low -> record row and lowest low column, stable count=1, go DEBOUNCE; else rotate row_n left one position (row0->row1->row2->row3->row0).
REQ-020 DEBOUNCE: row_n held; on tick, same column low -> count+1; different column low -> record it, count=1; no column low -> SCAN, row unchanged.
REQ-021 DEBOUNCE exit: count reaching DEBOUNCE -> PRESSED, key_valid asserted on the following clk.
REQ-022 PRESSED: exactly one key_valid per press; stays while any column low; on tick with no column low -> RELEASE, count=1.
REQ-023 RELEASE: on tick, no column low -> count+1, at DEBOUNCE -> SCAN; any column low -> PRESSED, no new event.
REQ-024 Multiple columns low in one row: lowest column index wins; keys in other rows are invisible until the return to SCAN.
REQ-025 Digit key, digit_count<MAX_DIGITS: operand <= operand*10 + digit, digit_count+1, in the key_valid cycle, visible the next clk.
REQ-026 Digit key, digit_count==MAX_DIGITS: key_valid still pulses; operand and digit_count unchanged.
REQ-027 Operator or EQ key: op_valid pulses with operand still holding the entry; operand and digit_count clear to 0 on the next clk.
REQ-028 CLR key: op_valid with op_code=5; operand and digit_count clear on the next clk.
REQ-029 clear_entry clears operand and digit_count on the next clk; if coincident with a digit key, the clear wins and the digit is dropped.
REQ-030 Arithmetic: operand*10 computed at 36 bits unsigned; 10 digits (max 9,999,999,999) SHALL NOT overflow; operand[35] always 0.

Reset
REQ-031 reset SHALL immediately set: row_n=4'b1110, state SCAN, scan counter 0, synchronizer flops 4'b1111, key_valid=0, op_valid=0, key_code=0, op_code=0, operand=0, digit_count=0.
REQ-032 reset mid-press: no key_valid after release; a key still held at reset exit is detected as a new press after DEBOUNCE ticks.

Structure
REQ-033 Shared package calc_pkg: op_code enum (ADD..CLR), 4x4 key-map constant, OPERAND_W=36.
REQ-034 Sub-module keypad_scan: synchronizer, tick, FSM, row drive; outputs key_valid and key_code; keypad_entry contains the decode and accumulator.

Verification
REQ-035 Press 1,2,3 each held 8 ticks -> three key_valid pulses, operand=123, digit_count=3.
REQ-036 Key 5 bounces (low 1 tick, high 1, low 1, then held) -> exactly one key_valid, key_code=5, operand=5.
REQ-037 Enter 11 digits of 9 -> eleven key_valid pulses, operand=9999999999, digit_count=10.
REQ-038 Enter 42 then ADD -> op_valid with op_code=0 while operand=42; next clk operand=0, digit_count=0.
REQ-039 Hold keys 7 and 8 together (row2, cols 0 and 1) -> key_code=8 (digit 7); no second event until both are released.
REQ-040 Assert reset during DEBOUNCE of key 6 -> outputs at reset values at once; no key_valid; with key held after reset exit, one key_valid after DEBOUNCE ticks.
